alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencer in front of the ALU. It accepts operation requests over a valid/ready command port and drives the ALU select and operand inputs. It captures the ALU result when the ALU signals valid, then returns the result over a valid/ready response port. Sits between the instruction decode/datapath control and the ALU, and is the only driver of the ALU's inputs.

## Interface
- TIMEOUT_CYC, 15: maximum WAIT-state cycles before a timeout error. Only used with the timeout feature; legal range 1..255.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- Cmd_Valid_i  in  1  command request valid.
- Cmd_Ready_o  out  1  block can accept a command.
- Cmd_Op_i  in  3  opcode: 1=ADD, 2=MUL, 3=SUB, 4=SHIFT. 0 and 5..7 are illegal.
- Cmd_A_i  in  8  operand A; drives ALU D0.
- Cmd_B_i  in  8  operand B; drives ALU D1 (shift amount for SHIFT).
- AluSel_o  out  3  ALU select.
- AluD0_o  out  8  ALU operand 0.
- AluD1_o  out  8  ALU operand 1.
- AluQ_i  in  8  ALU result.
- AluValid_i  in  1  ALU result valid.
- Rsp_Valid_o  out  1  response valid.
- Rsp_Ready_i  in  1  consumer accepts response.
- Rsp_Data_o  out  8  result.
- Rsp_Err_o  out  1  illegal opcode or timeout.
- OpCount_o  out  16  count of completed responses; wraps 0xFFFF->0x0000.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - Cmd_Ready_o=1.
  - On Cmd_Valid_i&Cmd_Ready_o, latch op, A and B.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with data 0x00, Err=1. The ALU is never driven.
- ISSUE: AluSel_o=latched op, AluD0_o=A, AluD1_o=B. Unconditionally go to WAIT. This is a settle cycle for the combinational ALU.
- WAIT:
  - ALU outputs are held.
  - If AluValid_i=1, capture AluQ_i into the result register with Err=0, then go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - Rsp_Valid_o=1. Rsp_Data_o and Rsp_Err_o are stable while valid.
  - On Rsp_Ready_i=1, go to IDLE and increment OpCount_o.
- Outside ISSUE and WAIT: AluSel_o=0 (NOP), AluD0_o=AluD1_o=0x00.
- Data is passed through unchanged. The 8-bit ALU result is already truncated, and the block does no arithmetic on it.
- Cmd_Ready_o=0 in every state except IDLE, so there is one outstanding operation at a time.

## Timing
- Reset values:
  - Cmd_Ready_o=0 while rst is high, 1 in the first cycle after release.
  - AluSel_o=0, AluD0_o=0x00, AluD1_o=0x00.
  - Rsp_Valid_o=0, Rsp_Data_o=0x00, Rsp_Err_o=0, OpCount_o=0.
- Legal op with AluValid_i=1 (cycle 0 is the accept edge):
  - ISSUE in cycle 1.
  - WAIT in cycle 2; capture on that edge.
  - Rsp_Valid_o=1 from cycle 3.
- Illegal op: Rsp_Valid_o=1 in cycle 1.
- With Rsp_Ready_i held 1, Cmd_Ready_o returns 1 in the cycle after the response handshake. Legal-op throughput is one per 4 cycles.
- Response and new command never overlap, because Cmd_Ready_o=0 in RESP.
- rst in any state, including mid-WAIT or mid-RESP:
  - Next cycle is IDLE with all outputs at reset values.
  - OpCount_o clears.
  - The in-flight operation is dropped with no response.
- Cmd_Valid_i may drop without a handshake. Commands are sampled only on accept.

## Configuration
- ALU_ISSUE_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without AluValid_i.
  - When the counter reaches TIMEOUT_CYC, go to RESP with data 0x00 and Err=1, and drive AluSel_o back to 0.
  - AluValid_i in the same cycle as expiry wins and gives a normal result.
- ALU_ISSUE_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely.
  - Rsp_Err_o is set only for an illegal op.
  - TIMEOUT_CYC is ignored.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants OP_NOP=3'h0, OP_ADD=3'h1, OP_MUL=3'h2, OP_SUB=3'h3, OP_SHIFT=3'h4.
  - The ALU data width (8) and select width (3).
  - The FSM state encoding typedef.
- One sub-module: alu_issue_wdog, the timeout counter. It is instantiated only under ALU_ISSUE_TIMEOUT_EN, with inputs start/valid and output expire.

## Test plan
- ADD, A=0x05, B=0x03, AluValid_i tied 1, Rsp_Ready_i=1 -> Rsp_Valid_o in cycle 3, Rsp_Data_o=0x08, Err=0, OpCount_o=1.
- MUL, A=0x10, B=0x10 -> AluSel_o=2 in cycles 1-2, Rsp_Data_o=0x00 (ALU-truncated value), Err=0.
- Op=0 and op=7 -> Rsp_Valid_o in cycle 1, data 0x00, Err=1, AluSel_o stays 0 throughout.
- SUB 0x03-0x05 with Rsp_Ready_i low 5 cycles -> Rsp_Data_o=0xFE held stable, Cmd_Ready_o=0 throughout, then IDLE one cycle after ready.
- TIMEOUT_EN, TIMEOUT_CYC=4, AluValid_i=0 -> Err=1 and data 0x00 after 4 WAIT cycles. Without the macro, the block is still in WAIT after 100 cycles.
- rst asserted in WAIT and in RESP -> all outputs at reset values next cycle, no response, OpCount_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, data/select widths and the issue FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_DW = 8;
    localparam int unsigned ALU_SW = 3;

    localparam logic [ALU_SW-1:0] OP_NOP   = 3'h0;
    localparam logic [ALU_SW-1:0] OP_ADD   = 3'h1;
    localparam logic [ALU_SW-1:0] OP_MUL   = 3'h2;
    localparam logic [ALU_SW-1:0] OP_SUB   = 3'h3;
    localparam logic [ALU_SW-1:0] OP_SHIFT = 3'h4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    function automatic logic op_is_legal(input logic [ALU_SW-1:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SUB) || (op == OP_SHIFT);
    endfunction

endpackage

// File: rtl/alu_issue_wdog.sv
// WAIT-state timeout counter for alu_issue_ctrl; only instantiated when ALU_ISSUE_TIMEOUT_EN is defined.
module alu_issue_wdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic valid,
    output logic expire
);

    logic [7:0] count;
    logic       running;
    logic       at_limit;

    // Expiry fires in the WAIT cycle whose miss brings the count to TIMEOUT_CYC.
    assign at_limit = (count == 8'(TIMEOUT_CYC - 1));
    assign expire   = running && !valid && at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (valid || at_limit) begin
                count   <= '0;
                running <= 1'b0;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-outstanding ALU sequencer: command handshake -> ALU issue/wait -> response handshake.
// Optional WAIT timeout enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Cmd_Valid_i,
    output logic              Cmd_Ready_o,
    input  logic [ALU_SW-1:0] Cmd_Op_i,
    input  logic [ALU_DW-1:0] Cmd_A_i,
    input  logic [ALU_DW-1:0] Cmd_B_i,
    output logic [ALU_SW-1:0] AluSel_o,
    output logic [ALU_DW-1:0] AluD0_o,
    output logic [ALU_DW-1:0] AluD1_o,
    input  logic [ALU_DW-1:0] AluQ_i,
    input  logic              AluValid_i,
    output logic              Rsp_Valid_o,
    input  logic              Rsp_Ready_i,
    output logic [ALU_DW-1:0] Rsp_Data_o,
    output logic              Rsp_Err_o,
    output logic [15:0]       OpCount_o
);

    state_t            state, state_n;
    logic [ALU_SW-1:0] op_q, op_n;
    logic [ALU_DW-1:0] a_q, a_n;
    logic [ALU_DW-1:0] b_q, b_n;
    logic [ALU_DW-1:0] data_q, data_n;
    logic              err_q, err_n;
    logic [15:0]       count_q;
    logic              accept;
    logic              alu_active;
    logic              wd_expire;

`ifdef ALU_ISSUE_TIMEOUT_EN
    alu_issue_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .start (state == ST_ISSUE),
        .valid (AluValid_i),
        .expire(wd_expire)
    );
`else
    // Legal TIMEOUT_CYC is never 0, so the wait never expires in this build.
    assign wd_expire = (TIMEOUT_CYC == 0);
`endif

    // Ready is gated by rst so it reads 0 even before the first reset edge settles the state.
    assign Cmd_Ready_o = (state == ST_IDLE) && !rst;
    assign accept      = Cmd_Valid_i && Cmd_Ready_o;
    assign alu_active  = (state == ST_ISSUE) || (state == ST_WAIT);

    assign AluSel_o    = alu_active ? op_q : OP_NOP;
    assign AluD0_o     = alu_active ? a_q  : '0;
    assign AluD1_o     = alu_active ? b_q  : '0;

    assign Rsp_Valid_o = (state == ST_RESP);
    assign Rsp_Data_o  = data_q;
    assign Rsp_Err_o   = err_q;
    assign OpCount_o   = count_q;

    always_comb begin
        state_n = state;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        data_n  = data_q;
        err_n   = err_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_n = Cmd_Op_i;
                    a_n  = Cmd_A_i;
                    b_n  = Cmd_B_i;
                    if (op_is_legal(Cmd_Op_i)) begin
                        state_n = ST_ISSUE;
                    end else begin
                        data_n  = '0;
                        err_n   = 1'b1;
                        state_n = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (AluValid_i) begin
                    data_n  = AluQ_i;
                    err_n   = 1'b0;
                    state_n = ST_RESP;
                end else if (wd_expire) begin
                    data_n  = '0;
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (Rsp_Ready_i) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            a_q    <= a_n;
            b_q    <= b_n;
            data_q <= data_n;
            err_q  <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if ((state == ST_RESP) && Rsp_Ready_i) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed latency/reset cases plus randomized traffic.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Cmd_Valid_i = 1'b0;
    logic       Cmd_Ready_o;
    logic [2:0] Cmd_Op_i = 3'd0;
    logic [7:0] Cmd_A_i = 8'd0;
    logic [7:0] Cmd_B_i = 8'd0;
    logic [2:0] AluSel_o;
    logic [7:0] AluD0_o;
    logic [7:0] AluD1_o;
    logic [7:0] AluQ_i;
    logic       AluValid_i = 1'b1;
    logic       Rsp_Valid_o;
    logic       Rsp_Ready_i = 1'b1;
    logic [7:0] Rsp_Data_o;
    logic       Rsp_Err_o;
    logic [15:0] OpCount_o;

    alu_issue_ctrl #(
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Cmd_Valid_i(Cmd_Valid_i),
        .Cmd_Ready_o(Cmd_Ready_o),
        .Cmd_Op_i   (Cmd_Op_i),
        .Cmd_A_i    (Cmd_A_i),
        .Cmd_B_i    (Cmd_B_i),
        .AluSel_o   (AluSel_o),
        .AluD0_o    (AluD0_o),
        .AluD1_o    (AluD1_o),
        .AluQ_i     (AluQ_i),
        .AluValid_i (AluValid_i),
        .Rsp_Valid_o(Rsp_Valid_o),
        .Rsp_Ready_i(Rsp_Ready_i),
        .Rsp_Data_o (Rsp_Data_o),
        .Rsp_Err_o  (Rsp_Err_o),
        .OpCount_o  (OpCount_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_cnt = 0;
    bit   rand_valid = 1'b0;
    bit   rand_ready = 1'b0;
    logic fix_valid = 1'b1;
    logic fix_ready = 1'b1;
    int   miss_run = 0;

    // Behavioural ALU: result of an 8-bit op, truncated to 8 bits.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return p[7:0];
            3'd3:    return a - b;
            3'd4:    return a << b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit legal_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    assign AluQ_i = alu_fn(AluSel_o, AluD0_o, AluD1_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU valid and response ready, either fixed or random, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rand_valid) begin
            if (miss_run >= 2) AluValid_i = 1'b1;
            else AluValid_i = ($urandom_range(0, 3) != 0);
            miss_run = AluValid_i ? 0 : miss_run + 1;
        end else begin
            AluValid_i = fix_valid;
        end
        Rsp_Ready_i = rand_ready ? 1'($urandom_range(0, 1)) : fix_ready;
    end

    // Monitor: pops the scoreboard on every response handshake.
    logic [7:0] prev_data;
    logic       prev_err;
    bit         prev_hold = 1'b0;
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            exp_q.delete();
            exp_cnt   = 0;
            prev_hold = 1'b0;
        end else begin
            if (Rsp_Valid_o) chk("cmd_ready_in_resp", 32'(Cmd_Ready_o), 32'd0);
            if (Rsp_Valid_o && prev_hold) begin
                chk("rsp_data_stable", 32'(Rsp_Data_o), 32'(prev_data));
                chk("rsp_err_stable", 32'(Rsp_Err_o), 32'(prev_err));
            end
            if (Rsp_Valid_o && Rsp_Ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL rsp_unexpected: got data 0x%0h err %0b, required no response", Rsp_Data_o, Rsp_Err_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(Rsp_Data_o), 32'(e.data));
                    chk("rsp_err", 32'(Rsp_Err_o), 32'(e.err));
                end
                chk("opcount", 32'(OpCount_o), 32'(exp_cnt));
                exp_cnt   = (exp_cnt + 1) & 16'hFFFF;
                prev_hold = 1'b0;
            end else begin
                prev_hold = Rsp_Valid_o;
                prev_data = Rsp_Data_o;
                prev_err  = Rsp_Err_o;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit to_err, output bit ok);
        rsp_t e;
        @(posedge clk);
        #1;
        Cmd_Valid_i = 1'b1;
        Cmd_Op_i    = op;
        Cmd_A_i     = a;
        Cmd_B_i     = b;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (Cmd_Ready_o) ok = 1'b1;
        end
        if (ok) begin
            if (to_err || !legal_op(op)) e = '{data: 8'h00, err: 1'b1};
            else e = '{data: alu_fn(op, a, b), err: 1'b0};
            exp_q.push_back(e);
        end else begin
            n_cmp++;
            n_mis++;
            $display("FAIL cmd_accept_timeout: Cmd_Ready_o=%0b, required 1 within 300 cycles", Cmd_Ready_o);
        end
        @(posedge clk);
        #1;
        Cmd_Valid_i = 1'b0;
        Cmd_Op_i    = 3'($urandom);
        Cmd_A_i     = 8'($urandom);
        Cmd_B_i     = 8'($urandom);
    endtask

    // Counts negedges after the accept edge until Rsp_Valid_o (cycle 1 is the first).
    task automatic wait_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (Rsp_Valid_o) break;
            if (legal_op(op) && n <= 2) begin
                chk("alu_sel_issue", 32'(AluSel_o), 32'(op));
                chk("alu_d0_issue", 32'(AluD0_o), 32'(a));
                chk("alu_d1_issue", 32'(AluD1_o), 32'(b));
            end
            if (!legal_op(op)) chk("alu_sel_illegal", 32'(AluSel_o), 32'd0);
        end
    endtask

    task automatic directed(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        int n;
        send(op, a, b, 1'b0, ok);
        wait_rsp(op, a, b, n);
        chk("rsp_latency", 32'(n), legal_op(op) ? 32'd3 : 32'd1);
        chk("alu_sel_in_resp", 32'(AluSel_o), 32'd0);
        @(negedge clk);
        chk("cmd_ready_after_rsp", 32'(Cmd_Ready_o), 32'd1);
        chk("rsp_valid_after_rsp", 32'(Rsp_Valid_o), 32'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", 32'(Cmd_Ready_o), 32'd0);
        chk("rst_alu_sel", 32'(AluSel_o), 32'd0);
        chk("rst_alu_d0", 32'(AluD0_o), 32'd0);
        chk("rst_alu_d1", 32'(AluD1_o), 32'd0);
        chk("rst_rsp_valid", 32'(Rsp_Valid_o), 32'd0);
        chk("rst_rsp_data", 32'(Rsp_Data_o), 32'd0);
        chk("rst_rsp_err", 32'(Rsp_Err_o), 32'd0);
        chk("rst_opcount", 32'(OpCount_o), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(Cmd_Ready_o), 32'd1);
        chk("opcount_after_rst", 32'(OpCount_o), 32'd0);
    endtask

    initial begin
        bit ok;
        int n;
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_first", 32'(Cmd_Ready_o), 32'd1);

        directed(3'd1, 8'h05, 8'h03);
        chk("opcount_after_add", 32'(OpCount_o), 32'd1);
        directed(3'd2, 8'h10, 8'h10);
        directed(3'd4, 8'h81, 8'h03);
        directed(3'd0, 8'h12, 8'h34);
        directed(3'd7, 8'hAA, 8'h55);

        // SUB held in RESP for five cycles with the consumer stalled
        fix_ready = 1'b0;
        send(3'd3, 8'h03, 8'h05, 1'b0, ok);
        wait_rsp(3'd3, 8'h03, 8'h05, n);
        for (int i = 0; i < 5; i++) begin
            chk("sub_hold_valid", 32'(Rsp_Valid_o), 32'd1);
            chk("sub_hold_data", 32'(Rsp_Data_o), 32'hFE);
            chk("sub_hold_cmd_ready", 32'(Cmd_Ready_o), 32'd0);
            @(negedge clk);
        end
        fix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("sub_idle_after_ready", 32'(Cmd_Ready_o), 32'd1);

`ifdef ALU_ISSUE_TIMEOUT_EN
        fix_valid = 1'b0;
        send(3'd1, 8'h11, 8'h22, 1'b1, ok);
        wait_rsp(3'd1, 8'h11, 8'h22, n);
        chk("timeout_latency", 32'(n), 32'(2 + TB_TIMEOUT));
        chk("timeout_alu_sel", 32'(AluSel_o), 32'd0);
        @(negedge clk);
        fix_valid = 1'b1;
`else
        fix_valid = 1'b0;
        send(3'd1, 8'h11, 8'h22, 1'b0, ok);
        repeat (100) @(negedge clk);
        chk("no_timeout_rsp_valid", 32'(Rsp_Valid_o), 32'd0);
        chk("no_timeout_alu_sel", 32'(AluSel_o), 32'd1);
        do_reset();
        fix_valid = 1'b1;
`endif

        // Reset mid-WAIT
        fix_valid = 1'b0;
        send(3'd2, 8'h07, 8'h09, 1'b0, ok);
        repeat (3) @(negedge clk);
        chk("in_wait_alu_sel", 32'(AluSel_o), 32'd2);
        do_reset();
        fix_valid = 1'b1;

        // Reset mid-RESP
        fix_ready = 1'b0;
        send(3'd1, 8'h40, 8'h02, 1'b0, ok);
        wait_rsp(3'd1, 8'h40, 8'h02, n);
        chk("in_resp_valid", 32'(Rsp_Valid_o), 32'd1);
        do_reset();
        fix_ready = 1'b1;

        // Randomized traffic
        rand_valid = 1'b1;
        rand_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0, ok);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_valid = 1'b0;
        rand_ready = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_opcount", 32'(OpCount_o), 32'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
